// File: rtl/shift_arbiter.sv
// ============================================================================
// Module  : shift_arbiter
// Brief   : Round-robin sharing of one iterative 32-bit shift unit among
//           NUM_REQ requesters; zero-amount shifts are answered locally.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  output logic [NUM_REQ-1:0]      o_req_ready,
  input  logic [NUM_REQ*32-1:0]   i_req_a,
  input  logic [NUM_REQ*32-1:0]   i_req_b,
  input  logic [NUM_REQ-1:0]      i_req_lshift,
  input  logic [NUM_REQ-1:0]      i_req_unsigned,
  output logic [NUM_REQ-1:0]      o_resp_valid,
  output logic [31:0]             o_resp_q,
  output logic                    o_sh_kick,
  output logic [31:0]             o_sh_a,
  output logic [31:0]             o_sh_b,
  output logic                    o_sh_lshift,
  output logic                    o_sh_unsigned,
  input  logic                    i_sh_ready,
  input  logic                    i_sh_done,
  input  logic [31:0]             i_sh_q
);

  localparam int c_IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_SW = c_IW + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RESP_ZERO = 2'd1,
    S_KICK      = 2'd2,
    S_WAIT      = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_IW-1:0]      r_rr;
  logic [c_IW-1:0]      r_owner;
  logic [31:0]          r_a;
  logic [4:0]           r_shamt;
  logic                 r_lshift;
  logic                 r_unsigned;
  logic                 r_kick;
  logic [NUM_REQ-1:0]   r_resp_valid;
  logic [31:0]          r_resp_q;

  logic                 w_found;
  logic [c_IW-1:0]      w_gnt_idx;
  logic [c_SW-1:0]      w_sum;
  logic                 w_accept;
  logic [31:0]          w_sel_a;
  logic [4:0]           w_sel_shamt;
  logic                 w_sel_lshift;
  logic                 w_sel_unsigned;
  logic                 w_unused_b;

  // Search starts just after the last winner and wraps, so the winner drops to lowest priority.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum = {1'b0, r_rr} + c_SW'(k);
      if (w_sum >= c_SW'(NUM_REQ)) begin
        w_sum = w_sum - c_SW'(NUM_REQ);
      end
      if (!w_found && i_req_valid[w_sum[c_IW-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_sum[c_IW-1:0];
      end
    end
  end

  assign w_accept       = (r_state == S_IDLE) && i_sh_ready && w_found;
  assign w_sel_a        = i_req_a[32*int'(w_gnt_idx) +: 32];
  assign w_sel_shamt    = i_req_b[32*int'(w_gnt_idx) +: 5];
  assign w_sel_lshift   = i_req_lshift[w_gnt_idx];
  assign w_sel_unsigned = i_req_unsigned[w_gnt_idx];
  assign w_unused_b     = ^i_req_b;

  always_comb begin
    o_req_ready = '0;
    if (w_accept) begin
      o_req_ready[w_gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_rr         <= c_IW'(NUM_REQ - 1);
      r_owner      <= '0;
      r_a          <= '0;
      r_shamt      <= '0;
      r_lshift     <= 1'b0;
      r_unsigned   <= 1'b0;
      r_kick       <= 1'b0;
      r_resp_valid <= '0;
      r_resp_q     <= '0;
    end else begin
      r_resp_valid <= '0;
      r_kick       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a        <= w_sel_a;
            r_shamt    <= w_sel_shamt;
            r_lshift   <= w_sel_lshift;
            r_unsigned <= w_sel_unsigned;
            r_owner    <= w_gnt_idx;
            r_rr       <= w_gnt_idx;
            // Zero shift: the answer is the operand, presented during RESP_ZERO (accept + 1).
            if (w_sel_shamt == 5'd0) begin
              r_resp_valid[w_gnt_idx] <= 1'b1;
              r_resp_q                <= w_sel_a;
              r_state                 <= S_RESP_ZERO;
            end else begin
              r_kick  <= 1'b1;
              r_state <= S_KICK;
            end
          end
        end
        S_RESP_ZERO: r_state <= S_IDLE;
        S_KICK:      r_state <= S_WAIT;
        S_WAIT: begin
          // The unit clears done at the kick edge, so done seen here belongs to this op.
          if (i_sh_done) begin
            r_resp_valid[r_owner] <= 1'b1;
            r_resp_q              <= i_sh_q;
            r_state               <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_resp_valid  = r_resp_valid;
  assign o_resp_q      = r_resp_q;
  assign o_sh_kick     = r_kick;
  assign o_sh_a        = r_a;
  assign o_sh_b        = {27'b0, r_shamt};
  assign o_sh_lshift   = r_lshift;
  assign o_sh_unsigned = r_unsigned;

endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
// ============================================================================
// Module  : tb_shift_arbiter
// Brief   : Scoreboard bench for shift_arbiter with a 1-bit/cycle shift unit
//           model and a behavioural arbitration/latency reference.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_shift_arbiter;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid, req_ready, req_l, req_u, resp_valid;
  logic [N*32-1:0] req_a, req_b;
  logic [31:0]     resp_q, sh_a, sh_b, sh_q;
  logic            sh_kick, sh_l, sh_u, sh_ready, sh_done;

  always #5 clk = ~clk;

  shift_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b),
    .i_req_lshift(req_l), .i_req_unsigned(req_u),
    .o_resp_valid(resp_valid), .o_resp_q(resp_q),
    .o_sh_kick(sh_kick), .o_sh_a(sh_a), .o_sh_b(sh_b),
    .o_sh_lshift(sh_l), .o_sh_unsigned(sh_u),
    .i_sh_ready(sh_ready), .i_sh_done(sh_done), .i_sh_q(sh_q)
  );

  // Iterative shift unit: one bit per cycle, fill mode sampled every busy cycle.
  logic [4:0]  u_cnt;
  logic [31:0] u_q;
  logic        u_done;
  logic        blk;
  assign sh_ready = (u_cnt == 5'd0) && !blk;
  assign sh_done  = u_done;
  assign sh_q     = u_q;

  always @(posedge clk) begin
    if (reset) begin
      u_cnt <= '0; u_q <= '0; u_done <= 1'b0;
    end else if (sh_kick) begin
      u_q <= sh_a; u_cnt <= sh_b[4:0]; u_done <= 1'b0;
    end else if (u_cnt != 5'd0) begin
      u_q   <= sh_l ? {u_q[30:0], 1'b0} : (sh_u ? {1'b0, u_q[31:1]} : {u_q[31], u_q[31:1]});
      u_cnt <= u_cnt - 5'd1;
      if (u_cnt == 5'd1) u_done <= 1'b1;
    end
  end

  typedef struct {
    int          owner;
    logic [31:0] q;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          glog[$];
  int          cyc = 0;
  int          errors = 0, checks = 0;
  int          free_cyc = 0, rr_m = N - 1;
  int          kicks_exp = 0, kicks_seen = 0;
  bit          rnd_en = 1'b0, rearm = 1'b0, nxt_blk = 1'b0;
  logic [N-1:0] pv, pl, pu;
  logic [31:0] pa[N], pb[N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input int n,
                                            input logic l, input logic u);
    if (l) return a << n;
    if (u) return a >> n;
    return 32'($signed(a) >>> n);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  exp_t me;
  always @(negedge clk) begin
    if (sb.size() != 0 && sb[0].due < cyc) begin
      me = sb.pop_front();
      chk("resp_missing_cycle", 32'(cyc), 32'(me.due));
    end
    if (resp_valid != '0) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", 32'(resp_valid), 32'd0);
      end else begin
        me = sb.pop_front();
        chk("resp_owner", 32'(resp_valid), 32'(1 << me.owner));
        chk("resp_q", resp_q, me.q);
        chk("resp_cycle", 32'(cyc), 32'(me.due));
      end
    end
  end

  always @(negedge clk) begin
    if (sh_kick) begin
      kicks_seen++;
      chk("sh_b_upper", {5'b0, sh_b[31:5]}, 32'd0);
    end
  end

  task automatic step();
    int w;
    exp_t e;
    @(posedge clk); #1;
    if (rnd_en) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i]) begin
          pa[i] = $urandom;
          pu[i] = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 3) == 0) begin
            pv[i] = 1'b1;
            pb[i] = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFE0) : $urandom;
            pl[i] = 1'($urandom_range(0, 1));
          end
        end else if ($urandom_range(0, 31) == 0) begin
          pv[i] = 1'b0;
        end
      end
      nxt_blk = ($urandom_range(0, 15) == 0);
    end
    blk = nxt_blk;
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = pv[i];
      req_a[32*i +: 32]  = pa[i];
      req_b[32*i +: 32]  = pb[i];
      req_l[i]           = pl[i];
      req_u[i]           = pu[i];
    end
    @(negedge clk);
    w = -1;
    if (cyc >= free_cyc && sh_ready && req_valid != '0) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (rr_m + k) % N;
        if (w < 0 && req_valid[idx]) w = idx;
      end
    end
    chk("req_ready", 32'(req_ready), (w >= 0) ? 32'(1 << w) : 32'd0);
    for (int i = 0; i < N; i++) if (req_ready[i]) glog.push_back(i);
    if (w >= 0) begin
      int n;
      n       = int'(req_b[32*w +: 5]);
      e.owner = w;
      e.q     = ref_shift(req_a[32*w +: 32], n, req_l[w], req_u[w]);
      if (n == 0) begin
        e.due    = cyc + 1;
        free_cyc = cyc + 2;
      end else begin
        e.due    = cyc + n + 3;
        free_cyc = e.due;
        kicks_exp++;
      end
      rr_m = w;
      sb.push_back(e);
      if (!rearm) pv[w] = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && (sb.size() != 0 || pv != '0); i++) step();
    chk("drain_timeout", 32'(sb.size() != 0 || pv != '0), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; pv = '0; req_valid = '0;
    @(posedge clk); #1;
    sb.delete(); free_cyc = 0; rr_m = N - 1;
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_sh_kick", 32'(sh_kick), 32'd0);
    chk("rst_resp_q", resp_q, 32'd0);
    chk("rst_sh_a", sh_a, 32'd0);
    chk("rst_sh_b", sh_b, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic l, input logic u);
    pv[i] = 1'b1; pa[i] = a; pb[i] = b; pl[i] = l; pu[i] = u;
  endtask

  initial begin
    int exp_ord[4] = '{0, 1, 0, 1};
    int k0;
    pv = '0; pl = '0; pu = '0; blk = 1'b0;
    for (int i = 0; i < N; i++) begin pa[i] = '0; pb[i] = '0; end
    req_valid = '0; req_a = '0; req_b = '0; req_l = '0; req_u = '0;
    repeat (2) @(posedge clk);
    do_reset();

    set_req(0, 32'h0000_00F0, 32'd4, 1'b1, 1'b0);
    wait_idle();
    set_req(1, 32'h8000_0000, 32'h21, 1'b0, 1'b0);
    wait_idle();
    set_req(1, 32'h8000_0000, 32'h21, 1'b0, 1'b1);
    wait_idle();

    k0 = kicks_seen;
    set_req(0, 32'h1234_5678, 32'd32, 1'b1, 1'b0);
    wait_idle();
    chk("zero_no_kick", 32'(kicks_seen - k0), 32'd0);

    nxt_blk = 1'b1;
    set_req(0, 32'hDEAD_BEEF, 32'd3, 1'b0, 1'b0);
    repeat (5) step();
    nxt_blk = 1'b0;
    wait_idle();

    do_reset();
    glog.delete();
    rearm = 1'b1;
    set_req(0, 32'h0000_0001, 32'd2, 1'b1, 1'b0);
    set_req(1, 32'hCAFE_0000, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 200 && glog.size() < 4; i++) step();
    rearm = 1'b0; pv = '0;
    chk("grant_count", 32'(glog.size()), 32'd4);
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("grant_order", 32'(glog[i]), 32'(exp_ord[i]));
    wait_idle();

    set_req(0, 32'h8765_4321, 32'd31, 1'b0, 1'b0);
    repeat (12) step();
    do_reset();
    set_req(1, 32'h0F0F_0F0F, 32'd5, 1'b0, 1'b1);
    wait_idle();

    rnd_en = 1'b1;
    repeat (800) step();
    rnd_en = 1'b0; nxt_blk = 1'b0;
    wait_idle();
    repeat (3) step();

    chk("kick_count", 32'(kicks_seen), 32'(kicks_exp));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
